// File: rtl/phi_pkg.sv
// ---------------------------------------------------------------------------
// phi_pkg
//
// Purpose : Definitions shared by the phi sequencer, its read pipeline and the
//           phi evaluator. The package holds the sequencer state enum, the
//           default geometry of one phi evaluation and the vector typedefs
//           used to carry T values and phi results.
//
// Contents:
//   phi_width()      - address/counter width for a given count (never below 1)
//   PHI_*            - default geometry (T width, formant count, nu values,
//                      interval depth, memory read latency, wait timeout)
//   PHI_CNT_W        - width of an interval count 0..K_MAX
//   PHI_ADDR_W       - width of a T-memory address 0..K_MAX-1
//   PHI_TO_W         - width of the result-wait timeout counter
//   phi_seq_state_t  - sequencer FSM states
//   t_vec_t/f_vec_t  - one interval of T values / one set of phi results
// ---------------------------------------------------------------------------
package phi_pkg;

  // Width needed to hold 0..depth-1, clamped to one bit so that degenerate
  // depths never produce zero-width vectors.
  function automatic int phi_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int PHI_BIT_WIDTH    = 32;
  localparam int PHI_FORMANTS     = 5;
  localparam int PHI_NU_VALUES    = 3;
  localparam int PHI_K_MAX        = 16;
  localparam int PHI_READ_LATENCY = 2;
  localparam int PHI_TIMEOUT      = 4096;

  localparam int PHI_CNT_W  = phi_width(PHI_K_MAX + 1);
  localparam int PHI_ADDR_W = phi_width(PHI_K_MAX);
  localparam int PHI_TO_W   = phi_width(PHI_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } phi_seq_state_t;

  // Element 0 sits in the least significant BIT_WIDTH bits of the flat bus.
  typedef logic [PHI_NU_VALUES-1:0][PHI_BIT_WIDTH-1:0] t_vec_t;
  typedef logic [PHI_FORMANTS-1:0][PHI_BIT_WIDTH-1:0]  f_vec_t;

endpackage

// File: rtl/phi_rd_pipe.sv
// ---------------------------------------------------------------------------
// phi_rd_pipe
//
// Purpose : Fixed-latency valid tracker for a BRAM-style reader. A read strobe
//           entering on valid_i leaves on valid_o exactly LATENCY cycles later,
//           lined up with the memory's read data. A synchronous flush drops
//           every read still in flight, including one presented in the same
//           cycle as the flush.
//
// Ports:
//   clk_i       - clock
//   rst_ni      - asynchronous active-low reset, empties the pipeline
//   valid_i     - read strobe issued this cycle
//   flush_i     - discard all in-flight reads at the next edge
//   valid_o     - read data is valid this cycle
//   inflight_o  - a read is still in flight behind the one now on valid_o,
//                 i.e. the pipeline will not be empty next cycle even if no
//                 new read is issued
// ---------------------------------------------------------------------------
module phi_rd_pipe #(
  parameter int LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic flush_i,
  output logic valid_o,
  output logic inflight_o
);

  // Every stage except the output stage. Empty for LATENCY = 1.
  localparam logic [LATENCY-1:0] EARLY_MASK = LATENCY'((1 << (LATENCY - 1)) - 1);

  // Stage 0 (LSB) holds the youngest read, stage LATENCY-1 the oldest.
  logic [LATENCY-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = (stage_q << 1) | LATENCY'(valid_i);
    if (flush_i) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o    = stage_q[LATENCY-1];
  assign inflight_o = |(stage_q & EARLY_MASK);

endmodule

// File: rtl/phi_sequencer.sv
// ---------------------------------------------------------------------------
// phi_sequencer
//
// Purpose : Runs one phi evaluation per utterance frame. On an accepted start
//           it kicks phi, streams N intervals of T values from the T-value
//           memory into phi with a contiguous valid burst, waits for phi's
//           results, latches them and reports done or timeout.
//
// Ports:
//   clk_in            - system clock
//   rst_in            - asynchronous active-low reset
//   start_in          - request one evaluation (sampled only while idle)
//   num_intervals_in  - interval count N, sampled together with start_in
//   abort_in          - cancel the evaluation in progress
//   t_rd_out          - T-memory read strobe
//   t_addr_out        - T-memory address (0 whenever no read is issued)
//   t_data_in         - T-memory read data, READ_LATENCY cycles after t_rd_out
//   phi_start_out     - phi input_start
//   phi_valid_out     - phi input_valid
//   phi_t_out         - phi T_vals, zero whenever phi_valid_out is low
//   phi_data_in       - phi output_data
//   phi_valid_in      - phi output_valid
//   result_out        - results of the last completed evaluation
//   busy_out          - evaluation in progress
//   done_out          - one-cycle pulse, result_out holds new results
//   err_out           - one-cycle pulse after a rejected start or a timeout
//
// Handshake: phi_start_out is a single-cycle pulse, followed by exactly N
// cycles of phi_valid_out with no gaps, each carrying one interval on
// phi_t_out. phi_valid_in is a single-cycle qualifier for phi_data_in and is
// honoured only while the sequencer is waiting for results; anywhere else it
// is dropped. There is no back-pressure in either direction.
//
// The FSM state is held in state_q (phi_seq_state_t) for observation.
// ---------------------------------------------------------------------------
module phi_sequencer
  import phi_pkg::*;
#(
  parameter int BIT_WIDTH    = PHI_BIT_WIDTH,
  parameter int FORMANTS     = PHI_FORMANTS,
  parameter int NU_VALUES    = PHI_NU_VALUES,
  parameter int K_MAX        = PHI_K_MAX,
  parameter int READ_LATENCY = PHI_READ_LATENCY,
  parameter int TIMEOUT      = PHI_TIMEOUT
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              start_in,
  input  logic [phi_width(K_MAX+1)-1:0]     num_intervals_in,
  input  logic                              abort_in,
  output logic                              t_rd_out,
  output logic [phi_width(K_MAX)-1:0]       t_addr_out,
  input  logic [BIT_WIDTH*NU_VALUES-1:0]    t_data_in,
  output logic                              phi_start_out,
  output logic                              phi_valid_out,
  output logic [BIT_WIDTH*NU_VALUES-1:0]    phi_t_out,
  input  logic [BIT_WIDTH*FORMANTS-1:0]     phi_data_in,
  input  logic                              phi_valid_in,
  output logic [BIT_WIDTH*FORMANTS-1:0]     result_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              err_out
);

  localparam int CNT_W  = phi_width(K_MAX + 1);
  localparam int ADDR_W = phi_width(K_MAX);
  localparam int TO_W   = phi_width(TIMEOUT);
  localparam int RES_W  = BIT_WIDTH * FORMANTS;

  localparam logic [CNT_W-1:0] N_MAX   = CNT_W'(K_MAX);
  localparam logic [CNT_W-1:0] N_ONE   = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  phi_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;           // intervals in this evaluation
  logic [ADDR_W-1:0]  addr_q, addr_d;     // next T-memory address
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d; // cycles spent waiting for phi
  logic [RES_W-1:0]   result_q, result_d;
  logic               err_q, err_d;

  // Combinational controls
  logic rd_issue;
  logic kick;
  logic done_pulse;
  logic pipe_flush;
  logic pipe_valid;
  logic pipe_inflight;
  logic n_ok;
  logic last_addr;

  assign n_ok      = (num_intervals_in != '0) && (num_intervals_in <= N_MAX);
  assign last_addr = (CNT_W'(addr_q) == (n_q - N_ONE));

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    addr_d     = addr_q;
    to_cnt_d   = to_cnt_q;
    result_d   = result_q;
    err_d      = 1'b0;
    rd_issue   = 1'b0;
    kick       = 1'b0;
    done_pulse = 1'b0;
    pipe_flush = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (n_ok) begin
            n_d     = num_intervals_in;
            state_d = ST_KICK;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_KICK: begin
        kick    = 1'b1;
        addr_d  = '0;
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        rd_issue = 1'b1;
        if (last_addr) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      // Leave as soon as only the oldest read remains: it is delivered this
      // cycle, so WAIT starts the cycle after the last phi_valid_out.
      ST_DRAIN: begin
        if (!pipe_inflight) begin
          to_cnt_d = '0;
          state_d  = ST_WAIT;
        end
      end

      // A response on the final counted cycle still wins over the timeout.
      ST_WAIT: begin
        if (phi_valid_in) begin
          result_d = phi_data_in;
          state_d  = ST_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_DONE: begin
        done_pulse = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the state above decided: back to idle, drop
    // in-flight reads, keep the old results and report nothing.
    if (abort_in && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      result_d   = result_q;
      err_d      = 1'b0;
      done_pulse = 1'b0;
      pipe_flush = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      addr_q   <= '0;
      to_cnt_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      to_cnt_q <= to_cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline: turns each read strobe into phi_valid_out READ_LATENCY
  // cycles later, when the matching T values are on t_data_in.
  // -------------------------------------------------------------------------
  phi_rd_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .valid_i    (rd_issue),
    .flush_i    (pipe_flush),
    .valid_o    (pipe_valid),
    .inflight_o (pipe_inflight)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign t_rd_out      = rd_issue;
  assign t_addr_out    = rd_issue ? addr_q : '0;
  assign phi_start_out = kick;
  assign phi_valid_out = pipe_valid;
  // Memory data is only meaningful on valid cycles; keep the bus quiet
  // otherwise so phi never sees stale T values.
  assign phi_t_out     = pipe_valid ? t_data_in : '0;
  assign result_out    = result_q;
  assign busy_out      = (state_q != ST_IDLE);
  assign done_out      = done_pulse;
  assign err_out       = err_q;

endmodule

// File: tb/tb_phi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phi_sequencer
//
// Bench for phi_sequencer with READ_LATENCY=2, K_MAX=16 and TIMEOUT=16.
// Expected behaviour of each evaluation comes from the cycle-level timing
// rules (kick at cycle 1, reads on cycles 2..N+1, valids RL cycles later,
// WAIT from N+2+RL, done/err positions, abort cut-off), evaluated per cycle.
// ---------------------------------------------------------------------------
module tb_phi_sequencer;

  localparam int BW = 32;
  localparam int FM = 5;
  localparam int NU = 3;
  localparam int KM = 16;
  localparam int RL = 2;
  localparam int TO = 16;
  localparam int DW = BW * NU;
  localparam int RW = BW * FM;
  localparam int NW = $clog2(KM + 1);
  localparam int AW = $clog2(KM);

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  // ---------------- DUT signals ----------------
  logic          start_in;
  logic [NW-1:0] num_intervals_in;
  logic          abort_in;
  logic          t_rd_out;
  logic [AW-1:0] t_addr_out;
  logic [DW-1:0] t_data_in;
  logic          phi_start_out;
  logic          phi_valid_out;
  logic [DW-1:0] phi_t_out;
  logic [RW-1:0] phi_data_in;
  logic          phi_valid_in;
  logic [RW-1:0] result_out;
  logic          busy_out;
  logic          done_out;
  logic          err_out;

  phi_sequencer #(
    .BIT_WIDTH    (BW),
    .FORMANTS     (FM),
    .NU_VALUES    (NU),
    .K_MAX        (KM),
    .READ_LATENCY (RL),
    .TIMEOUT      (TO)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .num_intervals_in (num_intervals_in),
    .abort_in         (abort_in),
    .t_rd_out         (t_rd_out),
    .t_addr_out       (t_addr_out),
    .t_data_in        (t_data_in),
    .phi_start_out    (phi_start_out),
    .phi_valid_out    (phi_valid_out),
    .phi_t_out        (phi_t_out),
    .phi_data_in      (phi_data_in),
    .phi_valid_in     (phi_valid_in),
    .result_out       (result_out),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .err_out          (err_out)
  );

  // ---------------- T-memory model (fixed RL read latency) ----------------
  logic [DW-1:0] mem [KM];
  logic          rd_dly [RL];
  logic [AW-1:0] ad_dly [RL];
  logic [DW-1:0] junk;

  always @(posedge clk_in) begin
    for (int i = RL - 1; i > 0; i--) begin
      rd_dly[i] <= rd_dly[i-1];
      ad_dly[i] <= ad_dly[i-1];
    end
    rd_dly[0] <= t_rd_out;
    ad_dly[0] <= t_addr_out;
    junk      <= {$urandom, $urandom, $urandom};
  end

  // Garbage outside read-data cycles so any leak onto phi_t_out shows up.
  assign t_data_in = rd_dly[RL-1] ? mem[ad_dly[RL-1]] : junk;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [RW-1:0] prev_result;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_res();
    logic [RW-1:0] r;
    for (int i = 0; i < FM; i++) r[i*BW +: BW] = $urandom;
    return r;
  endfunction

  // ---------------- driver + per-cycle reference ----------------
  // n: intervals, d: phi response delay after entering WAIT (-1 = never),
  // ab: abort cycle (-1 = none), hold: keep start_in high while busy,
  // spur: stray phi_valid_in during the first read cycle.
  // Starts and ends one time unit after a rising edge.
  task automatic run_eval(input string tag, input int n, input int d, input int ab,
                          input bit hold, input bit spur, input logic [RW-1:0] resp);
    int w, fin, stop, lastc, abc;
    bit answered, aborted, latched;
    logic [RW-1:0] exp_res;
    logic [DW-1:0] got_t;
    w        = n + 2 + RL;
    answered = (d >= 0) && (d < TO);
    fin      = answered ? w + d + 2 : w + TO;
    abc      = (ab < 0) ? (1 << 20) : ab;
    aborted  = abc < fin;
    stop     = aborted ? abc + 1 : fin;
    latched  = answered && (w + d < abc);
    lastc    = stop;
    if (d >= 0 && w + d > lastc) lastc = w + d;
    lastc = lastc + 1;
    exp_q.delete();
    for (int k = 0; k < n; k++) if (2 + k + RL <= abc) exp_q.push_back(mem[k]);

    for (int c = 0; c <= lastc; c++) begin
      bit act, rd, pv, dn, er;
      start_in         = (c == 0) || (hold && c < stop);
      num_intervals_in = NW'(n);
      abort_in         = (c == abc);
      phi_valid_in     = 1'b0;
      phi_data_in      = rand_res();
      if (spur && c == 2) phi_valid_in = 1'b1;
      if (d >= 0 && c == w + d) begin
        phi_valid_in = 1'b1;
        phi_data_in  = resp;
      end
      @(negedge clk_in);
      act     = (c >= 1) && (c < stop);
      rd      = act && (c >= 2) && (c <= n + 1);
      pv      = (c >= 2 + RL) && (c <= n + 1 + RL) && (c <= abc);
      dn      = answered && (c == w + d + 1) && (c < abc);
      er      = !answered && !aborted && (c == fin);
      exp_res = (latched && c >= w + d + 1) ? resp : prev_result;
      chk($sformatf("%s c%0d busy", tag, c), RW'(busy_out), RW'(act));
      chk($sformatf("%s c%0d phi_start", tag, c), RW'(phi_start_out), RW'(act && c == 1));
      chk($sformatf("%s c%0d t_rd", tag, c), RW'(t_rd_out), RW'(rd));
      chk($sformatf("%s c%0d t_addr", tag, c), RW'(t_addr_out), rd ? RW'(c - 2) : '0);
      chk($sformatf("%s c%0d phi_valid", tag, c), RW'(phi_valid_out), RW'(pv));
      if (phi_valid_out && exp_q.size() > 0) got_t = exp_q.pop_front();
      else got_t = '0;
      chk($sformatf("%s c%0d phi_t", tag, c), RW'(phi_t_out), pv ? RW'(got_t) : '0);
      chk($sformatf("%s c%0d done", tag, c), RW'(done_out), RW'(dn));
      chk($sformatf("%s c%0d err", tag, c), RW'(err_out), RW'(er));
      chk($sformatf("%s c%0d result", tag, c), result_out, exp_res);
      @(posedge clk_in);
      #1;
    end
    chk($sformatf("%s leftover reads", tag), RW'(exp_q.size()), '0);
    start_in     = 1'b0;
    abort_in     = 1'b0;
    phi_valid_in = 1'b0;
    if (latched) prev_result = resp;
  endtask

  // ---------------- table of start requests ----------------
  typedef struct {
    logic [NW-1:0] num;
    bit            exp_err;
    bit            exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [RW-1:0] r15;
    vecs[0] = '{num: 5'd0,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{num: 5'd17, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{num: 5'd31, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{num: 5'd1,  exp_err: 1'b0, exp_busy: 1'b1};
    vecs[4] = '{num: 5'd16, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[5] = '{num: 5'd5,  exp_err: 1'b0, exp_busy: 1'b1};

    rst_in           = 1'b0;
    start_in         = 1'b0;
    num_intervals_in = '0;
    abort_in         = 1'b0;
    phi_valid_in     = 1'b0;
    phi_data_in      = '0;
    prev_result      = '0;
    for (int k = 0; k < KM; k++) mem[k] = {BW'(k + 2), BW'(k + 1), BW'(k)};

    // ---- reset values ----
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst busy", RW'(busy_out), '0);
    chk("rst done", RW'(done_out), '0);
    chk("rst err", RW'(err_out), '0);
    chk("rst t_rd", RW'(t_rd_out), '0);
    chk("rst t_addr", RW'(t_addr_out), '0);
    chk("rst phi_start", RW'(phi_start_out), '0);
    chk("rst phi_valid", RW'(phi_valid_out), '0);
    chk("rst phi_t", RW'(phi_t_out), '0);
    chk("rst result", result_out, '0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // ---- start acceptance / rejection table ----
    for (int i = 0; i < 6; i++) begin
      start_in         = 1'b1;
      num_intervals_in = vecs[i].num;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      @(negedge clk_in);
      chk($sformatf("tbl%0d err", i), RW'(err_out), RW'(vecs[i].exp_err));
      chk($sformatf("tbl%0d busy", i), RW'(busy_out), RW'(vecs[i].exp_busy));
      chk($sformatf("tbl%0d phi_start", i), RW'(phi_start_out), RW'(vecs[i].exp_busy));
      chk($sformatf("tbl%0d t_rd", i), RW'(t_rd_out), '0);
      if (vecs[i].exp_busy) abort_in = 1'b1;
      @(posedge clk_in);
      #1;
      abort_in = 1'b0;
      @(negedge clk_in);
      chk($sformatf("tbl%0d idle busy", i), RW'(busy_out), '0);
      chk($sformatf("tbl%0d idle err", i), RW'(err_out), '0);
      chk($sformatf("tbl%0d idle t_rd", i), RW'(t_rd_out), '0);
      @(posedge clk_in);
      #1;
    end

    // ---- reference evaluation: N=3, results {1..5} ----
    r15 = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    run_eval("basic", 3, 3, -1, 1'b0, 1'b0, r15);
    chk("basic result held", result_out, r15);

    // ---- phi silent: timeout, prior result held ----
    run_eval("timeout", 4, -1, -1, 1'b0, 1'b0, '0);
    // ---- abort during ISSUE at addr 2 of N=8, then a clean run ----
    run_eval("abort", 8, 5, 4, 1'b0, 1'b0, rand_res());
    run_eval("after_abort", 5, 0, -1, 1'b0, 1'b0, rand_res());
    // ---- start held high plus stray phi_valid_in ----
    run_eval("hold_spur", 6, 2, -1, 1'b1, 1'b1, rand_res());
    // ---- boundaries: last counted cycle, just too late, N extremes ----
    run_eval("d15", 2, 15, -1, 1'b0, 1'b0, rand_res());
    run_eval("d16", 2, 16, -1, 1'b0, 1'b0, rand_res());
    run_eval("n16", 16, 0, -1, 1'b0, 1'b0, rand_res());
    run_eval("n1", 1, 0, -1, 1'b0, 1'b0, rand_res());
    // ---- abort racing a response in WAIT, and abort in DONE ----
    run_eval("abort_wait", 3, 2, 3 + 2 + RL + 2, 1'b0, 1'b0, rand_res());
    run_eval("abort_done", 3, 2, 3 + 2 + RL + 3, 1'b0, 1'b0, rand_res());

    // ---- randomized evaluations ----
    for (int it = 0; it < 24; it++) begin
      int n, d, ab, w, fin, mode;
      n = $urandom_range(1, KM);
      for (int k = 0; k < KM; k++) mem[k] = {$urandom, $urandom, $urandom};
      mode = $urandom_range(0, 9);
      if (mode == 0) d = -1;
      else if (mode == 1) d = $urandom_range(TO, TO + 4);
      else d = $urandom_range(0, TO - 1);
      w   = n + 2 + RL;
      fin = (d >= 0 && d < TO) ? w + d + 2 : w + TO;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, fin - 1) : -1;
      run_eval($sformatf("rnd%0d", it), n, d, ab, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), rand_res());
    end

    // ---- asynchronous reset in the middle of WAIT ----
    start_in         = 1'b1;
    num_intervals_in = NW'(2);
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    repeat (2 + 2 + RL) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    chk("arst pre busy", RW'(busy_out), RW'(1));
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst busy", RW'(busy_out), '0);
    chk("arst done", RW'(done_out), '0);
    chk("arst err", RW'(err_out), '0);
    chk("arst t_rd", RW'(t_rd_out), '0);
    chk("arst phi_valid", RW'(phi_valid_out), '0);
    chk("arst phi_t", RW'(phi_t_out), '0);
    chk("arst result", result_out, '0);
    #1;
    rst_in = 1'b1;
    prev_result = '0;
    @(posedge clk_in);
    #1;
    run_eval("post_rst", 2, 1, -1, 1'b0, 1'b0, rand_res());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
